// File: rtl/alu_unit.sv
// Registered ALU with built-in aluop/funct decoder: ADD, SUB, AND, OR, optional SLT.
// Define ALU_SLT_EN to add the SLT operation (funct 101010); otherwise it decodes as illegal.
module alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam int MSB = WIDTH - 1;

    logic             sub, sel_or, sel_arith, sel_slt, illegal_dec;
    logic [WIDTH-1:0] b_eff, sum, logic_res;
    logic             add_ovf, slt_bit;

    logic [WIDTH-1:0] result_d, result_q;
    logic             zero_d, zero_q;
    logic             overflow_d, overflow_q;
    logic             illegal_d, illegal_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sub         = 1'b0;
        sel_or      = 1'b0;
        sel_arith   = 1'b1;
        sel_slt     = 1'b0;
        illegal_dec = 1'b0;
        case (aluop)
            2'b00: ;
            2'b01: sub = 1'b1;
            2'b11: begin
                sel_or    = 1'b1;
                sel_arith = 1'b0;
            end
            default: begin
                case (funct)
                    6'b100000: ;
                    6'b100010: sub = 1'b1;
                    6'b100100: sel_arith = 1'b0;
                    6'b100101: begin
                        sel_or    = 1'b1;
                        sel_arith = 1'b0;
                    end
`ifdef ALU_SLT_EN
                    6'b101010: begin
                        sub     = 1'b1;
                        sel_slt = 1'b1;
                    end
`endif
                    default: illegal_dec = 1'b1;
                endcase
            end
        endcase
    end

    // Logic ops leave sub=0, so zero on AND/OR reports a+b == 0.
    always_comb begin
        b_eff     = b ^ {WIDTH{sub}};
        sum       = a + b_eff + WIDTH'(sub);
        add_ovf   = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]);
        slt_bit   = sum[MSB] ^ add_ovf;
        logic_res = sel_or ? (a | b) : (a & b);
    end

    always_comb begin
        result_d   = result_q;
        zero_d     = zero_q;
        overflow_d = overflow_q;
        illegal_d  = illegal_q;
        if (en) begin
            if (sel_slt)
                result_d = WIDTH'(slt_bit);
            else if (sel_arith)
                result_d = sum;
            else
                result_d = logic_res;
            zero_d     = (sum == '0);
            overflow_d = sel_arith && !sel_slt && add_ovf;
            illegal_d  = illegal_dec;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q   <= '0;
            zero_q     <= 1'b1;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            result_q   <= result_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vectors plus randomized traffic against
// an arithmetic reference model. Honours ALU_SLT_EN the same way the design does.
module tb_alu_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a, b;
    logic [31:0] result;
    logic        zero, overflow, illegal;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_r;
    logic        exp_z, exp_o, exp_i;

    alu_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .en(en), .aluop(aluop), .funct(funct),
        .a(a), .b(b), .result(result), .zero(zero), .overflow(overflow), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference model: pick the operation, then evaluate with plain signed arithmetic.
    function automatic void model(input logic [1:0] op, input logic [5:0] f,
                                  input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic z,
                                  output logic o, output logic il);
        longint sx, sy, s;
        logic [31:0] tmp;
        string kind;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        il = 1'b0;
        case (op)
            2'b00: kind = "add";
            2'b01: kind = "sub";
            2'b11: kind = "or";
            default: begin
                if (f == 6'h20) kind = "add";
                else if (f == 6'h22) kind = "sub";
                else if (f == 6'h24) kind = "and";
                else if (f == 6'h25) kind = "or";
`ifdef ALU_SLT_EN
                else if (f == 6'h2A) kind = "slt";
`endif
                else begin
                    kind = "add";
                    il   = 1'b1;
                end
            end
        endcase
        o = 1'b0;
        if (kind == "add" || kind == "sub") begin
            s = (kind == "add") ? sx + sy : sx - sy;
            r = (kind == "add") ? x + y : x - y;
            o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            z = (r == 32'd0);
        end else if (kind == "slt") begin
            r = (sx < sy) ? 32'd1 : 32'd0;
            z = (x == y);
        end else begin
            r   = (kind == "and") ? (x & y) : (x | y);
            tmp = x + y;
            z   = (tmp == 32'd0);
        end
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".result"},   result,          exp_r);
        check({tag, ".zero"},     {31'd0, zero},     {31'd0, exp_z});
        check({tag, ".overflow"}, {31'd0, overflow}, {31'd0, exp_o});
        check({tag, ".illegal"},  {31'd0, illegal},  {31'd0, exp_i});
    endtask

    task automatic step(input string tag, input logic e, input logic [1:0] op,
                        input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        en = e; aluop = op; funct = f; a = x; b = y;
        if (e) model(op, f, x, y, exp_r, exp_z, exp_o, exp_i);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_reset_expect();
        exp_r = 32'd0; exp_z = 1'b1; exp_o = 1'b0; exp_i = 1'b0;
    endtask

    logic [5:0] funct_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [31:0] corner_tab [5] = '{32'h0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h1};

    initial begin
        reset = 1'b1; en = 1'b0; aluop = 2'b00; funct = 6'h00; a = '0; b = '0;
        set_reset_expect();
        repeat (2) @(posedge clk);
        #1;
        check_all("por");

        @(negedge clk);
        reset = 1'b0;

        step("add_5_7", 1'b1, 2'b00, 6'h00, 32'd5, 32'd7);
        check("add_5_7.const", result, 32'd12);

        // Reset between edges must clear outputs without a clock edge.
        #2;
        reset = 1'b1;
        set_reset_expect();
        #1;
        check_all("async_rst");

        // Capture pending during reset is discarded.
        @(negedge clk);
        en = 1'b1; aluop = 2'b00; a = 32'd100; b = 32'd1;
        @(posedge clk);
        #1;
        check_all("rst_discard");
        @(negedge clk);
        reset = 1'b0; en = 1'b0;
        @(posedge clk);
        #1;
        check_all("rst_release_hold");

        step("sub_eq", 1'b1, 2'b01, 6'h00, 32'h0000_1234, 32'h0000_1234);
        check("sub_eq.zero_const", {31'd0, zero}, 32'd1);
        step("sub_ovf", 1'b1, 2'b10, 6'h22, 32'h8000_0000, 32'd1);
        check("sub_ovf.const", result, 32'h7FFF_FFFF);
        check("sub_ovf.ovf_const", {31'd0, overflow}, 32'd1);
        step("and", 1'b1, 2'b10, 6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("and.const", result, 32'hF000_F000);
        step("or", 1'b1, 2'b10, 6'h25, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("or.const", result, 32'hFFF0_FFF0);
        step("aluop_or", 1'b1, 2'b11, 6'h3F, 32'h0000_00F0, 32'h0000_000F);
        step("add_ovf", 1'b1, 2'b00, 6'h00, 32'h7FFF_FFFF, 32'd1);
        step("illegal", 1'b1, 2'b10, 6'h3F, 32'd1, 32'd2);
        check("illegal.const", result, 32'd3);
        check("illegal.flag_const", {31'd0, illegal}, 32'd1);
        step("hold", 1'b0, 2'b01, 6'h24, 32'hDEAD_BEEF, 32'h1234_5678);
        check("hold.const", result, 32'd3);

        step("slt_neg", 1'b1, 2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1);
`ifdef ALU_SLT_EN
        check("slt_neg.const", result, 32'd1);
        step("slt_swap", 1'b1, 2'b10, 6'h2A, 32'd1, 32'hFFFF_FFFF);
        check("slt_swap.const", result, 32'd0);
        step("slt_ovf", 1'b1, 2'b10, 6'h2A, 32'h8000_0000, 32'h7FFF_FFFF);
        check("slt_ovf.const", result, 32'd1);
`else
        check("slt_off.illegal_const", {31'd0, illegal}, 32'd1);
        check("slt_off.add_const", result, 32'd0);
`endif

        for (int i = 0; i < 300; i++) begin
            logic        e;
            logic [1:0]  op;
            logic [5:0]  f;
            logic [31:0] x, y;
            e  = ($urandom_range(0, 3) != 0);
            op = 2'($urandom_range(0, 3));
            f  = ($urandom_range(0, 1) == 0) ? funct_tab[$urandom_range(0, 4)] : 6'($urandom);
            x  = ($urandom_range(0, 3) == 0) ? corner_tab[$urandom_range(0, 4)] : $urandom;
            case ($urandom_range(0, 5))
                0: y = x;
                1: y = -x;
                2: y = corner_tab[$urandom_range(0, 4)];
                default: y = $urandom;
            endcase
            step("rand", e, op, f, x, y);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; all data ports and internal AND/OR/adder paths SHALL scale with it.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  capture strobe; result, zero, overflow and illegal register only when en=1.
REQ-005 aluop  input  2  operation class from the main control unit.
REQ-006 funct  input  6  instruction bits [5:0], decoded only when aluop=10.
REQ-007 a  input  WIDTH  operand A (register-file read port 1).
REQ-008 b  input  WIDTH  operand B (register read port 2 or sign-extended immediate).
REQ-009 result  output  WIDTH  registered ALU result.
REQ-010 zero  output  1  registered flag, 1 when the adder output equals 0.
REQ-011 overflow  output  1  registered signed-overflow flag.
REQ-012 illegal  output  1  registered flag, 1 when aluop=10 with an undecoded funct.

Function
REQ-013 The controller SHALL decode aluop as: 00 -> ADD; 01 -> SUB; 11 -> OR; 10 -> use funct.
REQ-014 Funct decoding SHALL be: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT (only with ALU_SLT_EN); any other funct -> ADD with illegal=1.
REQ-015 The controller SHALL produce three internal selects: sub (adder subtract), sel_or (logic path: 0=AND, 1=OR), sel_arith (final mux: 0=logic path, 1=adder path).
REQ-016 Adder path: sum = a + (b XOR {WIDTH{sub}}) + sub, modulo 2^WIDTH, with the carry-out discarded.
REQ-017 Logic path: bitwise a AND b, or bitwise a OR b, selected by sel_or.
REQ-018 zero SHALL reflect the adder output for every operation, including AND/OR (BEQ compatibility).
REQ-019 overflow SHALL be set for ADD/SUB when the operand signs and result sign indicate two's-complement overflow, and 0 for AND, OR and SLT.
REQ-020 Latency SHALL be 1 cycle: inputs sampled at rising edge N with en=1 appear on the outputs after edge N.
REQ-021 With en=0 all outputs SHALL hold their previous values.
REQ-022 Decoding and datapath SHALL be purely combinational between input sampling and the output registers; no other state exists.

Reset
REQ-023 While reset=1, outputs SHALL be result=0, zero=1, overflow=0, illegal=0, independent of clk.
REQ-024 Reset asserted mid-operation SHALL discard the pending capture; the first capture after deassertion occurs at the first rising edge with reset=0 and en=1.

Configuration
REQ-025 Macro ALU_SLT_EN, when defined, SHALL add SLT (funct 101010): result = {0..., 1} when signed(a) < signed(b), otherwise 0, computed from the SUB adder output with an overflow correction; zero follows the subtraction.
REQ-026 Without ALU_SLT_EN, funct 101010 SHALL decode as illegal (ADD with illegal=1).

Verification
REQ-027 Reset: assert reset between clock edges -> outputs result=0, zero=1, overflow=0, illegal=0 immediately.
REQ-028 aluop=00, a=5, b=7, en=1 -> after one edge result=12, zero=0, overflow=0.
REQ-029 aluop=01, a=b=0x0000_1234 -> result=0, zero=1; aluop=10, funct=100010, a=0x8000_0000, b=1 -> result=0x7FFF_FFFF, overflow=1.
REQ-030 aluop=10: funct=100100 with a=0xF0F0_F0F0, b=0xFF00_FF00 -> result=0xF000_F000; funct=100101 -> result=0xFFF0_FFF0; overflow=0 for both.
REQ-031 aluop=10, funct=111111, a=1, b=2 -> result=3, illegal=1; then en=0 with new inputs -> outputs unchanged.
REQ-032 With ALU_SLT_EN: a=0xFFFF_FFFF, b=1, funct=101010 -> result=1; swap a and b -> result=0; without the macro -> illegal=1.
